// File: rtl/cam_ram_reconfig_ctrl.sv
// Reconfiguration sequencer for a CAM/RAM array: stalls the owner, drains writes, applies new
// gating vectors and re-initialises the array through write port 0 whenever the RAM wakes up.
module cam_ram_reconfig_ctrl #(
  parameter int DEPTH        = 16,
  parameter int INDEX        = 4,
  parameter int WIDTH        = 8,
  parameter int NUM_WR_PORTS = 4,
  parameter int NUM_RD_PORTS = 4,
  parameter int RESET_VAL    = 0,   // 0: zero fill, 1: sequential fill from SEQ_START
  parameter int SEQ_START    = 0,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reconfigReq_i,
  input  logic [NUM_WR_PORTS-1:0] wrPortGatedNew_i,
  input  logic [NUM_RD_PORTS-1:0] rdPortGatedNew_i,
  input  logic                    ramGatedNew_i,
  input  logic                    wrBusy_i,
  output logic [NUM_WR_PORTS-1:0] writePortGated_o,
  output logic [NUM_RD_PORTS-1:0] readPortGated_o,
  output logic                    ramGated_o,
  output logic                    stall_o,
  output logic                    initWrEn_o,
  output logic [INDEX-1:0]        initAddr_o,
  output logic [WIDTH-1:0]        initData_o,
  output logic                    ramReady_o,
  output logic                    reconfigDone_o
);

  localparam int RAM_RESET_SEQ = 1;
  localparam int CW            = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_INIT, S_DONE} state_t;

  state_t                  r_state, w_state_next;
  logic [CW-1:0]           r_drain_cnt, w_drain_cnt_next;
  logic [INDEX-1:0]        r_init_addr, w_init_addr_next;
  logic [WIDTH-1:0]        r_init_data;
  logic [NUM_WR_PORTS-1:0] r_wr_new, r_wr_gated;
  logic [NUM_RD_PORTS-1:0] r_rd_new, r_rd_gated;
  logic                    r_ram_new, r_ram_gated;
  logic                    r_stall, r_init_wr_en, r_ram_ready, r_done;
  logic                    w_apply, w_ram_gated_next;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    w_init_addr_next = r_init_addr;
    w_apply          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_drain_cnt_next = '0;
        if (reconfigReq_i) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (wrBusy_i) begin
          w_drain_cnt_next = '0;
        end else if (r_drain_cnt == CW'(DRAIN_CYCLES - 1)) begin
          w_apply          = 1'b1;
          w_drain_cnt_next = '0;
          w_init_addr_next = '0;
          // Only a wake (gated -> ungated) needs the array contents rebuilt.
          w_state_next     = (r_ram_gated && !r_ram_new) ? S_INIT : S_DONE;
        end else begin
          w_drain_cnt_next = r_drain_cnt + 1'b1;
        end
      end
      S_INIT: begin
        if (r_init_addr == INDEX'(DEPTH - 1)) begin
          w_init_addr_next = '0;
          w_state_next     = S_DONE;
        end else begin
          w_init_addr_next = r_init_addr + 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    w_ram_gated_next = w_apply ? r_ram_new : r_ram_gated;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset clears every control register; there is no storage array here to leave unreset.
      r_state      <= S_IDLE;
      r_drain_cnt  <= '0;
      r_init_addr  <= '0;
      r_init_data  <= '0;
      r_wr_new     <= '0;
      r_rd_new     <= '0;
      r_ram_new    <= 1'b0;
      r_wr_gated   <= '0;
      r_rd_gated   <= '0;
      r_ram_gated  <= 1'b0;
      r_stall      <= 1'b0;
      r_init_wr_en <= 1'b0;
      r_ram_ready  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
      r_init_addr <= w_init_addr_next;
      if (r_state == S_IDLE && reconfigReq_i) begin
        r_wr_new  <= wrPortGatedNew_i & ~NUM_WR_PORTS'(1);  // port 0 carries init writes
        r_rd_new  <= rdPortGatedNew_i;
        r_ram_new <= ramGatedNew_i;
      end
      if (w_apply) begin
        r_wr_gated  <= r_wr_new;
        r_rd_gated  <= r_rd_new;
        r_ram_gated <= r_ram_new;
      end
      if (w_state_next == S_INIT && RESET_VAL == RAM_RESET_SEQ)
        r_init_data <= WIDTH'(SEQ_START + int'(w_init_addr_next));
      else
        r_init_data <= '0;
      r_stall      <= (w_state_next != S_IDLE);
      r_init_wr_en <= (w_state_next == S_INIT);
      r_done       <= (w_state_next == S_DONE);
      r_ram_ready  <= !w_ram_gated_next && (w_state_next != S_INIT);
    end
  end

  assign writePortGated_o = r_wr_gated;
  assign readPortGated_o  = r_rd_gated;
  assign ramGated_o       = r_ram_gated;
  assign stall_o          = r_stall;
  assign initWrEn_o       = r_init_wr_en;
  assign initAddr_o       = r_init_addr;
  assign initData_o       = r_init_data;
  assign ramReady_o       = r_ram_ready;
  assign reconfigDone_o   = r_done;

endmodule

// File: tb/tb_cam_ram_reconfig_ctrl.sv
// Directed bench for cam_ram_reconfig_ctrl: a per-cycle vector table plus hand-written
// sequences for sleep/wake init, reset during init, and requests outside IDLE.
module tb_cam_ram_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [3:0] wr_new, rd_new;
  logic       ram_new, busy;
  logic [3:0] wpg, rpg;
  logic       rg, stall, wren, ready, done;
  logic [2:0] addr;
  logic [7:0] data;

  int n_vec = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic rst, req; logic [3:0] wr, rd; logic ram, busy;
    logic stall; logic [3:0] wpg, rpg; logic rg, wren; logic [2:0] addr; logic [7:0] data;
    logic ready, done;
  } vec_t;

  vec_t tbl[19];

  always #5 clk = ~clk;

  cam_ram_reconfig_ctrl #(
    .DEPTH(6), .INDEX(3), .WIDTH(8), .NUM_WR_PORTS(4), .NUM_RD_PORTS(4),
    .RESET_VAL(1), .SEQ_START(32), .DRAIN_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .reconfigReq_i(req),
    .wrPortGatedNew_i(wr_new), .rdPortGatedNew_i(rd_new), .ramGatedNew_i(ram_new),
    .wrBusy_i(busy),
    .writePortGated_o(wpg), .readPortGated_o(rpg), .ramGated_o(rg), .stall_o(stall),
    .initWrEn_o(wren), .initAddr_o(addr), .initData_o(data), .ramReady_o(ready),
    .reconfigDone_o(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    reset = v.rst; req = v.req; wr_new = v.wr; rd_new = v.rd; ram_new = v.ram; busy = v.busy;
    @(posedge clk);
    #1;
    n_vec++;
    chk({tag, ".stall"}, 32'(stall), 32'(v.stall));
    chk({tag, ".wpg"},   32'(wpg),   32'(v.wpg));
    chk({tag, ".rpg"},   32'(rpg),   32'(v.rpg));
    chk({tag, ".rg"},    32'(rg),    32'(v.rg));
    chk({tag, ".wren"},  32'(wren),  32'(v.wren));
    chk({tag, ".addr"},  32'(addr),  32'(v.addr));
    chk({tag, ".data"},  32'(data),  32'(v.data));
    chk({tag, ".ready"}, 32'(ready), 32'(v.ready));
    chk({tag, ".done"},  32'(done),  32'(v.done));
  endtask

  initial begin
    // rst req wr rd ram busy | stall wpg rpg rg wren addr data ready done
    tbl[0]  = '{1,0,4'h0,4'h0,0,0, 0,4'h0,4'h0,0,0,3'd0,8'd0,0,0};
    tbl[1]  = '{1,0,4'h0,4'h0,0,0, 0,4'h0,4'h0,0,0,3'd0,8'd0,0,0};
    tbl[2]  = '{1,1,4'hF,4'hF,1,0, 0,4'h0,4'h0,0,0,3'd0,8'd0,0,0};  // req under reset ignored
    tbl[3]  = '{0,0,4'h0,4'h0,0,0, 0,4'h0,4'h0,0,0,3'd0,8'd0,1,0};
    tbl[4]  = '{0,1,4'hF,4'h5,0,0, 1,4'h0,4'h0,0,0,3'd0,8'd0,1,0};
    tbl[5]  = '{0,0,4'hF,4'h5,0,0, 1,4'h0,4'h0,0,0,3'd0,8'd0,1,0};
    tbl[6]  = '{0,0,4'hF,4'h5,0,0, 1,4'hE,4'h5,0,0,3'd0,8'd0,1,1};
    tbl[7]  = '{0,0,4'hF,4'h5,0,0, 0,4'hE,4'h5,0,0,3'd0,8'd0,1,0};
    tbl[8]  = '{0,1,4'h3,4'hF,0,1, 1,4'hE,4'h5,0,0,3'd0,8'd0,1,0};
    for (int i = 9; i <= 13; i++)
      tbl[i] = '{0,0,4'h3,4'hF,0,1, 1,4'hE,4'h5,0,0,3'd0,8'd0,1,0};
    tbl[14] = '{0,0,4'h3,4'hF,0,0, 1,4'hE,4'h5,0,0,3'd0,8'd0,1,0};
    tbl[15] = '{0,0,4'h3,4'hF,0,1, 1,4'hE,4'h5,0,0,3'd0,8'd0,1,0};
    tbl[16] = '{0,0,4'h3,4'hF,0,0, 1,4'hE,4'h5,0,0,3'd0,8'd0,1,0};
    tbl[17] = '{0,0,4'h3,4'hF,0,0, 1,4'h2,4'hF,0,0,3'd0,8'd0,1,1};
    tbl[18] = '{0,0,4'h3,4'hF,0,0, 0,4'h2,4'hF,0,0,3'd0,8'd0,1,0};

    reset = 1'b1; req = 1'b0; wr_new = '0; rd_new = '0; ram_new = 1'b0; busy = 1'b0;

    // Reset, basic request, drain with busy bursts.
    for (int i = 0; i < 19; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // Sleep, then wake with sequential init of 6 entries.
    apply_vec('{0,1,4'h2,4'hF,1,0, 1,4'h2,4'hF,0,0,3'd0,8'd0,1,0}, "slp1");
    apply_vec('{0,0,4'h2,4'hF,1,0, 1,4'h2,4'hF,0,0,3'd0,8'd0,1,0}, "slp2");
    apply_vec('{0,0,4'h2,4'hF,1,0, 1,4'h2,4'hF,1,0,3'd0,8'd0,0,1}, "slp3");
    apply_vec('{0,0,4'h2,4'hF,1,0, 0,4'h2,4'hF,1,0,3'd0,8'd0,0,0}, "slp4");
    apply_vec('{0,1,4'h0,4'h0,0,0, 1,4'h2,4'hF,1,0,3'd0,8'd0,0,0}, "wak1");
    apply_vec('{0,0,4'h0,4'h0,0,0, 1,4'h2,4'hF,1,0,3'd0,8'd0,0,0}, "wak2");
    for (int i = 0; i < 6; i++)
      apply_vec('{0,0,4'h0,4'h0,0,0, 1,4'h0,4'h0,0,1,3'(i),8'(32 + i),0,0},
                $sformatf("init%0d", i));
    apply_vec('{0,0,4'h0,4'h0,0,0, 1,4'h0,4'h0,0,0,3'd0,8'd0,1,1}, "wdone");
    apply_vec('{0,0,4'h0,4'h0,0,0, 0,4'h0,4'h0,0,0,3'd0,8'd0,1,0}, "widle");

    // Reset asserted during the third init cycle, then a fresh basic request.
    apply_vec('{0,1,4'h4,4'h8,1,0, 1,4'h0,4'h0,0,0,3'd0,8'd0,1,0}, "r_s1");
    apply_vec('{0,0,4'h4,4'h8,1,0, 1,4'h0,4'h0,0,0,3'd0,8'd0,1,0}, "r_s2");
    apply_vec('{0,0,4'h4,4'h8,1,0, 1,4'h4,4'h8,1,0,3'd0,8'd0,0,1}, "r_s3");
    apply_vec('{0,0,4'h4,4'h8,1,0, 0,4'h4,4'h8,1,0,3'd0,8'd0,0,0}, "r_s4");
    apply_vec('{0,1,4'h6,4'h3,0,0, 1,4'h4,4'h8,1,0,3'd0,8'd0,0,0}, "r_w1");
    apply_vec('{0,0,4'h6,4'h3,0,0, 1,4'h4,4'h8,1,0,3'd0,8'd0,0,0}, "r_w2");
    apply_vec('{0,0,4'h6,4'h3,0,0, 1,4'h6,4'h3,0,1,3'd0,8'd32,0,0}, "r_i0");
    apply_vec('{0,0,4'h6,4'h3,0,0, 1,4'h6,4'h3,0,1,3'd1,8'd33,0,0}, "r_i1");
    apply_vec('{0,0,4'h6,4'h3,0,0, 1,4'h6,4'h3,0,1,3'd2,8'd34,0,0}, "r_i2");
    apply_vec('{1,0,4'h6,4'h3,0,0, 0,4'h0,4'h0,0,0,3'd0,8'd0,0,0}, "r_rst");
    apply_vec('{0,0,4'h0,4'h0,0,0, 0,4'h0,4'h0,0,0,3'd0,8'd0,1,0}, "r_rel");
    for (int i = 4; i <= 7; i++) apply_vec(tbl[i], $sformatf("r_tbl%0d", i));

    // Requests pulsed during DRAIN and INIT must be ignored.
    apply_vec('{0,1,4'h8,4'h1,1,0, 1,4'hE,4'h5,0,0,3'd0,8'd0,1,0}, "ig_s1");
    apply_vec('{0,1,4'h7,4'hF,0,0, 1,4'hE,4'h5,0,0,3'd0,8'd0,1,0}, "ig_s2");
    apply_vec('{0,0,4'h7,4'hF,0,0, 1,4'h8,4'h1,1,0,3'd0,8'd0,0,1}, "ig_s3");
    apply_vec('{0,0,4'h7,4'hF,0,0, 0,4'h8,4'h1,1,0,3'd0,8'd0,0,0}, "ig_s4");
    apply_vec('{0,1,4'h5,4'h2,0,0, 1,4'h8,4'h1,1,0,3'd0,8'd0,0,0}, "ig_w1");
    apply_vec('{0,0,4'h5,4'h2,0,0, 1,4'h8,4'h1,1,0,3'd0,8'd0,0,0}, "ig_w2");
    apply_vec('{0,0,4'h5,4'h2,0,0, 1,4'h4,4'h2,0,1,3'd0,8'd32,0,0}, "ig_i0");
    apply_vec('{0,1,4'hF,4'hF,1,0, 1,4'h4,4'h2,0,1,3'd1,8'd33,0,0}, "ig_i1");
    for (int i = 2; i < 6; i++)
      apply_vec('{0,0,4'hF,4'hF,1,0, 1,4'h4,4'h2,0,1,3'(i),8'(32 + i),0,0},
                $sformatf("ig_i%0d", i));
    apply_vec('{0,0,4'hF,4'hF,1,0, 1,4'h4,4'h2,0,0,3'd0,8'd0,1,1}, "ig_done");
    apply_vec('{0,0,4'hF,4'hF,1,0, 0,4'h4,4'h2,0,0,3'd0,8'd0,1,0}, "ig_idle1");
    apply_vec('{0,0,4'hF,4'hF,1,0, 0,4'h4,4'h2,0,0,3'd0,8'd0,1,0}, "ig_idle2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
